// File: rtl/h2c_arb_pkg.sv
// h2c_arb_pkg: shared constants, FSM state type and round-robin search for the H2C stream arbiter
package h2c_arb_pkg;
  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int USR_W = 64;
  typedef enum logic {IDLE, BUSY} state_t;
  // first set bit of req[n-1:0] at or above ptr with wrap-around; -1 when req is empty
  function automatic int rr_first(input logic [7:0] req, input int ptr, input int n);
    int r;
    r = -1;
    for (int k = 7; k >= 0; k--)
      if (k < n && req[(ptr + k) % n]) r = (ptr + k) % n;
    return r;
  endfunction
endpackage

// File: rtl/h2c_rr_pick.sv
// h2c_rr_pick: combinational round-robin picker, request vector and pointer to one-hot grant plus index
module h2c_rr_pick
  import h2c_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  assign idx = W'(rr_first(8'(req), int'(ptr), N));
  assign gnt = rr_first(8'(req), int'(ptr), N) >= 0 ? N'(1) << idx : '0;
endmodule

// File: rtl/h2c_axis_rr_arbiter.sv
// h2c_axis_rr_arbiter: packet-granular round-robin mux of NUM_SRC AXI-Stream sources onto one registered master
// Optional byte-parity checking is built when H2C_ARB_PARITY_CHK_EN is defined.
module h2c_axis_rr_arbiter
  import h2c_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W = $clog2(NUM_SRC)
) (
  input  logic                       axi_aclk,
  input  logic                       axi_aresetn,
  input  logic [NUM_SRC-1:0]         src_en,
  input  logic [NUM_SRC*DATA_W-1:0]  s_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0]  s_tparity,
  input  logic [NUM_SRC*KEEP_W-1:0]  s_tkeep,
  input  logic [NUM_SRC*USR_W-1:0]   s_tusr,
  input  logic [NUM_SRC-1:0]         s_tlast,
  input  logic [NUM_SRC-1:0]         s_tvalid,
  output logic [NUM_SRC-1:0]         s_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic [KEEP_W-1:0]          m_tparity,
  output logic [KEEP_W-1:0]          m_tkeep,
  output logic [USR_W-1:0]           m_tusr,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [SRC_W-1:0]           grant_id,
  output logic                       busy,
  output logic                       par_err
);
  state_t state;
  logic [SRC_W-1:0] rr_ptr, pick_idx;
  logic [NUM_SRC-1:0] pick_gnt;
  logic out_free, acc;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_par, sel_keep;
  logic [USR_W-1:0] sel_usr;
  logic sel_last;
  h2c_rr_pick #(.N(NUM_SRC), .W(SRC_W)) u_pick (
    .req(s_tvalid & src_en),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  assign out_free = !m_tvalid || m_tready;
  assign busy = state == BUSY;
  assign s_tready = busy && out_free ? NUM_SRC'(1) << grant_id : '0;
  assign acc = busy && out_free && s_tvalid[grant_id];
  assign sel_data = s_tdata[grant_id*DATA_W +: DATA_W];
  assign sel_par = s_tparity[grant_id*KEEP_W +: KEEP_W];
  assign sel_keep = s_tkeep[grant_id*KEEP_W +: KEEP_W];
  assign sel_usr = s_tusr[grant_id*USR_W +: USR_W];
  assign sel_last = s_tlast[grant_id];
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
      m_tdata <= '0;
      m_tparity <= '0;
      m_tkeep <= '0;
      m_tusr <= '0;
    end else begin
      if (acc) begin
        m_tvalid <= 1'b1;
        m_tlast <= sel_last;
        m_tdata <= sel_data;
        m_tparity <= sel_par;
        m_tkeep <= sel_keep;
        m_tusr <= sel_usr;
      end else if (m_tready) m_tvalid <= 1'b0;
      if (state == IDLE) begin
        if (|pick_gnt) begin
          grant_id <= pick_idx;
          state <= BUSY;
        end
      end else if (acc && sel_last) begin
        state <= IDLE;
        rr_ptr <= grant_id == SRC_W'(NUM_SRC - 1) ? '0 : grant_id + 1'b1;
      end
    end
`ifdef H2C_ARB_PARITY_CHK_EN
  logic [KEEP_W-1:0] calc_par;
  always_comb
    for (int k = 0; k < KEEP_W; k++) calc_par[k] = ~^sel_data[8*k +: 8];
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) par_err <= 1'b0;
    else par_err <= acc && |(sel_keep & (sel_par ^ calc_par));
`else
  assign par_err = 1'b0;
`endif
endmodule

// File: tb/tb_h2c_axis_rr_arbiter.sv
// tb_h2c_axis_rr_arbiter: directed self-checking bench for the H2C round-robin stream arbiter
module tb_h2c_axis_rr_arbiter;
  localparam int N = 4;
  localparam int DW = 512;
  logic axi_aclk = 1'b0;
  logic axi_aresetn;
  logic [N-1:0] src_en, s_tlast, s_tvalid, s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N*64-1:0] s_tparity, s_tkeep, s_tusr;
  logic [DW-1:0] m_tdata;
  logic [63:0] m_tparity, m_tkeep, m_tusr;
  logic m_tlast, m_tvalid, m_tready, busy, par_err;
  logic [1:0] grant_id;
  int checks = 0, passed = 0, cyc = 0, pc = 0, pmis = 0;
  int len[N], npk[N], pk[N], b[N];
  logic [63:0] keep_mask[N];
  logic flip[N];
  logic [N-1:0] sr_or;
  logic [DW-1:0] lg_d[$];
  logic [63:0] lg_k[$];
  logic lg_l[$];
  int lg_c[$], lg_g[$];
  h2c_axis_rr_arbiter #(.NUM_SRC(N)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .src_en(src_en),
    .s_tdata(s_tdata), .s_tparity(s_tparity), .s_tkeep(s_tkeep), .s_tusr(s_tusr),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tparity(m_tparity), .m_tkeep(m_tkeep), .m_tusr(m_tusr),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .par_err(par_err)
  );
  always #5 axi_aclk = ~axi_aclk;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic logic [63:0] opar(input logic [DW-1:0] d);
    logic [63:0] p;
    for (int k = 0; k < 64; k++) p[k] = ~^d[8*k +: 8];
    return p;
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] d;
      d = DW'(i*256 + pk[i]*16 + b[i]);
      s_tvalid[i] = npk[i] > 0;
      s_tlast[i] = b[i] == len[i] - 1;
      s_tdata[i*DW +: DW] = d;
      s_tkeep[i*64 +: 64] = keep_mask[i];
      s_tusr[i*64 +: 64] = 64'(i);
      s_tparity[i*64 +: 64] = opar(d) ^ (flip[i] ? 64'h20 : 64'h0);
    end
  endtask
  task automatic tick();
    logic [N-1:0] f;
    f = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      lg_d.push_back(m_tdata);
      lg_k.push_back(m_tkeep);
      lg_l.push_back(m_tlast);
      lg_c.push_back(cyc);
      lg_g.push_back(int'(grant_id));
    end
    @(posedge axi_aclk);
    #1;
    cyc++;
    if (par_err) begin
      pc++;
      if (!m_tvalid) pmis++;
    end
    for (int i = 0; i < N; i++)
      if (f[i]) begin
        if (b[i] == len[i] - 1) begin
          b[i] = 0;
          pk[i]++;
          npk[i]--;
        end else b[i]++;
      end
    drive();
    sr_or |= s_tready;
  endtask
  task automatic rst();
    axi_aresetn = 1'b0;
    src_en = '1;
    m_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      len[i] = 1; npk[i] = 0; pk[i] = 0; b[i] = 0; flip[i] = 1'b0; keep_mask[i] = '1;
    end
    drive();
    repeat (2) @(posedge axi_aclk);
    #1;
    axi_aresetn = 1'b1;
    cyc = 0; pc = 0; pmis = 0; sr_or = '0;
    lg_d.delete(); lg_k.delete(); lg_l.delete(); lg_c.delete(); lg_g.delete();
  endtask
  initial begin
    logic rp[12];
    logic srt[12];
    rp = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    srt = '{0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    rst();
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_mlast", m_tlast, 0);
    chk("rst_mdata", m_tdata, 0);
    chk("rst_mkeep", {m_tparity, m_tkeep, m_tusr}, 0);
    chk("rst_srdy", s_tready, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", par_err, 0);
    npk[0] = 1; len[0] = 3;
    drive();
    #1;
    chk("t1_srdy_pre", s_tready, 0);
    tick();
    chk("t1_srdy_grant", s_tready, 4'b0001);
    chk("t1_busy", busy, 1);
    repeat (5) tick();
    chk("t1_nbeats", lg_d.size(), 3);
    for (int k = 0; k < 3 && k < lg_d.size(); k++) begin
      chk($sformatf("t1_data%0d", k), lg_d[k], DW'(k));
      chk($sformatf("t1_last%0d", k), lg_l[k], k == 2);
      chk($sformatf("t1_cyc%0d", k), lg_c[k], 2 + k);
    end
    chk("t1_busy_end", busy, 0);
    chk("t1_mvalid_end", m_tvalid, 0);
    npk[0] = 1; len[0] = 1; npk[1] = 1; len[1] = 1;
    drive();
    tick();
    chk("t1_rrptr_gid", grant_id, 1);
    rst();
    for (int i = 0; i < N; i++) begin
      npk[i] = 1; len[i] = 2; keep_mask[i] = 64'hF0 | 64'(i);
    end
    drive();
    repeat (15) tick();
    chk("t2_nbeats", lg_d.size(), 8);
    for (int k = 0; k < 8 && k < lg_d.size(); k++) begin
      chk($sformatf("t2_data%0d", k), lg_d[k], DW'((k/2)*256 + k%2));
      chk($sformatf("t2_keep%0d", k), lg_k[k], 64'hF0 | 64'(k/2));
      chk($sformatf("t2_cyc%0d", k), lg_c[k], 2 + 3*(k/2) + k%2);
      chk($sformatf("t2_gid%0d", k), lg_g[k], k/2);
    end
    rst();
    npk[0] = 1; len[0] = 4;
    drive();
    for (int j = 0; j < 12; j++) begin
      m_tready = rp[j];
      #1;
      chk($sformatf("t3_srdy%0d", j), s_tready[0], srt[j]);
      tick();
    end
    m_tready = 1'b1;
    chk("t3_nbeats", lg_d.size(), 4);
    for (int k = 0; k < 4 && k < lg_d.size(); k++)
      chk($sformatf("t3_data%0d", k), lg_d[k], DW'(k));
    rst();
    src_en = 4'b1010;
    for (int i = 0; i < N; i++) begin
      npk[i] = 2; len[i] = 2;
    end
    drive();
    repeat (16) tick();
    chk("t4_nbeats", lg_d.size(), 8);
    for (int k = 0; k < 8 && k < lg_d.size(); k++)
      chk($sformatf("t4_data%0d", k), lg_d[k], DW'(((k/2)%2 == 0 ? 1 : 3)*256 + (k/4)*16 + k%2));
    chk("t4_masked_srdy", {sr_or[2], sr_or[0]}, 0);
    rst();
    npk[1] = 1; len[1] = 5;
    drive();
    repeat (3) tick();
    chk("t5_pre_mvalid", m_tvalid, 1);
    chk("t5_pre_gid", grant_id, 1);
    axi_aresetn = 1'b0;
    #1;
    chk("t5_mvalid", m_tvalid, 0);
    chk("t5_mlast", m_tlast, 0);
    chk("t5_mdata", m_tdata, 0);
    chk("t5_srdy", s_tready, 0);
    chk("t5_gid", grant_id, 0);
    chk("t5_busy", busy, 0);
    rst();
    npk[2] = 1; len[2] = 1;
    drive();
    repeat (4) tick();
    chk("t5_new_nbeats", lg_d.size(), 1);
    if (lg_d.size() > 0) begin
      chk("t5_new_data", lg_d[0], DW'(512));
      chk("t5_new_gid", lg_g[0], 2);
    end
    rst();
    flip[0] = 1'b1; npk[0] = 1; pk[0] = 3;
    drive();
    repeat (4) tick();
`ifdef H2C_ARB_PARITY_CHK_EN
    chk("par_flip_keep", pc, 1);
`else
    chk("par_flip_keep", pc, 0);
`endif
    chk("par_align", pmis, 0);
    chk("par_data", lg_d.size() > 0 ? lg_d[0] : '1, DW'(48));
    rst();
    flip[0] = 1'b1; keep_mask[0] = ~64'h20; npk[0] = 1;
    drive();
    repeat (4) tick();
    chk("par_flip_nokeep", pc, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/h2c_axis_rr_arbiter.md
# h2c_axis_rr_arbiter

Round-robin, packet-granular arbiter that shares the single 512-bit MDMA H2C AXI-Stream master port between NUM_SRC upstream packet sources (per-queue H2C engines). A packet, once granted, is delivered contiguously from first beat to tlast. All master outputs are driven from a one-stage output register. Sits between the queue engines and the CPM H2C stream interface.

## Interface
- NUM_SRC, 4: number of requesters, 2..8.
- SRC_W, $clog2(NUM_SRC): grant index width.
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  asynchronous, active-low reset.
- src_en  in  NUM_SRC  per-source arbitration enable; a 0 masks the source from new grants.
- s_tdata  in  NUM_SRC*512  source data, source i at [i*512 +: 512].
- s_tparity  in  NUM_SRC*64  per-byte parity.
- s_tkeep  in  NUM_SRC*64  byte enables.
- s_tusr  in  NUM_SRC*64  sideband user field.
- s_tlast  in  NUM_SRC  end of packet.
- s_tvalid  in  NUM_SRC  source beat valid.
- s_tready  out  NUM_SRC  source beat accepted.
- m_tdata / m_tparity / m_tkeep / m_tusr  out  512/64/64/64  registered output beat.
- m_tlast, m_tvalid  out  1 each.
- m_tready  in  1  downstream accept.
- grant_id  out  SRC_W  currently or most recently granted source.
- busy  out  1  packet in progress (state BUSY).
- par_err  out  1  one-cycle pulse on parity mismatch (macro only).

## Operation
- FSM states: IDLE, BUSY.
- IDLE: on clock edge, if any (s_tvalid & src_en) is set, select the first set bit searching from rr_ptr upward with wrap-around. Load grant_id, go to BUSY. No beat moves in IDLE.
- BUSY: s_tready[grant_id] = !m_tvalid || m_tready. All other s_tready bits are 0.
- Beat transfer on s_tvalid[g] && s_tready[g]:
  - Load the output register with that source's tdata/tparity/tkeep/tusr/tlast.
  - Set m_tvalid = 1.
- When the accepted beat has tlast = 1:
  - Go to IDLE.
  - Set rr_ptr = (grant_id + 1) mod NUM_SRC.
- Output register: when m_tvalid && m_tready and no new beat is loaded the same cycle, m_tvalid clears to 0. It holds while m_tvalid && !m_tready.
- Clearing src_en[g] mid-packet does not abort the packet. The mask only affects the next grant.
- If the granted source drops s_tvalid mid-packet, the FSM stays in BUSY and waits. There is no timeout.
- A source that is valid but has src_en = 0 is never granted. Its s_tready stays 0.
- Payload fields pass through unmodified, including tkeep on non-last beats.

## Timing
- Reset values: m_tvalid = 0, m_tlast = 0, m_tdata/tparity/tkeep/tusr = 0, s_tready = 0, grant_id = 0, busy = 0, par_err = 0, rr_ptr = 0, state = IDLE.
- Grant latency: 1 cycle from s_tvalid seen in IDLE to s_tready asserted.
- Data latency: 1 cycle from source acceptance to m_tvalid.
- Full throughput inside a packet: 1 beat per cycle while m_tready = 1.
- Exactly one idle arbitration cycle between consecutive packets.
- s_tready is combinational from m_tready and state only. It never depends on s_tvalid.
- Reset asserted mid-packet:
  - All state clears immediately.
  - A partially delivered packet is lost.
  - Upstream sources are reset by the same axresetn.

## Configuration
- H2C_ARB_PARITY_CHK_EN defined:
  - On every accepted source beat, compute odd parity per byte of tdata (parity bit = ~^byte).
  - Compare against tparity for bytes with tkeep = 1.
  - Any mismatch pulses par_err for 1 cycle, aligned with the m_tvalid load.
  - Data still passes unmodified.
- Undefined: par_err is tied to 0 and no parity logic is built.

## Structure
- Shared package h2c_arb_pkg:
  - constants DATA_W = 512, KEEP_W = 64, USR_W = 64;
  - state enum {IDLE, BUSY};
  - a function for the round-robin first-set search.
- One natural sub-module: h2c_rr_pick. It is combinational: request vector, pointer → one-hot grant plus index. It is reusable by the C2H path.

## Test plan
- Single source 0, 3-beat packet, m_tready = 1:
  - s_tready[0] rises 1 cycle after s_tvalid.
  - m_tvalid is high for 3 consecutive cycles; m_tlast is on the 3rd.
  - busy falls after tlast; rr_ptr = 1.
- All 4 sources valid, each with a 2-beat packet:
  - Output order is sources 0, 1, 2, 3, with no interleaving.
  - Exactly 1 idle cycle between packets.
  - grant_id sequence is 0, 1, 2, 3.
- m_tready toggled 1, 0, 0, 1 during a 4-beat packet:
  - No beat is lost or duplicated.
  - Output data equals the source beats in order.
  - s_tready tracks !m_tvalid || m_tready.
- src_en = 4'b1010 with all sources valid: only sources 1 and 3 are granted, alternating; s_tready[0] and s_tready[2] stay 0.
- axi_aresetn pulled low after beat 2 of a 5-beat packet: the next cycle shows all outputs at reset values and state IDLE; a new packet is then granted normally.
- H2C_ARB_PARITY_CHK_EN defined, beat with byte 5 parity flipped and tkeep[5] = 1: par_err pulses once. The same flip with tkeep[5] = 0 gives no pulse.
